// File: rtl/cmt_layer_sequencer.sv
// cmt_layer_sequencer: prover-side control endpoint of the per-layer
// verifier link. It steps the layer engines in order (w0 precompute steps,
// then sum-check rounds, then the h-point evaluation), returns each result
// to the verifier as a coded strobe, and does no field arithmetic itself.
module cmt_layer_sequencer #(
   parameter int ninputs  = 8,
   parameter int ngates   = 8,
   parameter int F_NBITS  = 16,
   parameter int nhpoints = $clog2(ninputs) + 1
) (
   input  logic                           clk,
   input  logic                           rstb,
   input  logic                           i_en,
   input  logic                           i_restart,
   input  logic [F_NBITS-1:0]             i_tau,
   output logic                           o_ready_pulse,
   output logic [1:0]                     o_ready_code,
   output logic [nhpoints*F_NBITS-1:0]    o_data,
   output logic [F_NBITS-1:0]             o_tau_q,
   output logic                           o_pre_start,
   output logic [$clog2(ngates)-1:0]      o_pre_step,
   input  logic                           i_pre_done,
   output logic                           o_rnd_start,
   output logic [$clog2(2*$clog2(ninputs)):0] o_rnd_idx,
   output logic                           o_rnd_use_r,
   input  logic                           i_rnd_done,
   input  logic [3*F_NBITS-1:0]           i_rnd_fj,
   output logic                           o_h_start,
   input  logic                           i_h_done,
   input  logic [nhpoints*F_NBITS-1:0]    i_h_pts,
   output logic                           o_busy,
   output logic                           o_proto_err
);

   localparam int NROUNDS = 2 * $clog2(ninputs);
   localparam int NGBITS  = $clog2(ngates);
   localparam int RIW     = $clog2(NROUNDS) + 1;
   localparam int DW      = nhpoints * F_NBITS;
   localparam int FJW     = 3 * F_NBITS;
   localparam logic [NGBITS-1:0] LAST_STEP = NGBITS'(NGBITS - 1);
   localparam logic [RIW-1:0]    NRND_V    = RIW'(NROUNDS);

   localparam logic [1:0] CODE_PRE = 2'b00;
   localparam logic [1:0] CODE_FJ  = 2'b01;
   localparam logic [1:0] CODE_H   = 2'b10;

   // Elaboration-time guards on the parameter set.
   if (nhpoints != $clog2(ninputs) + 1) begin : g_bad_nhpoints
      $error("nhpoints is derived from ninputs and must not be overridden");
   end
   if (ngates < 2) begin : g_bad_ngates
      $error("ngates must be at least 2");
   end
   if (nhpoints < 3) begin : g_bad_ninputs
      $error("ninputs too small to hold the three round words");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_PRE_WAIT,
      ST_RND,
      ST_RND_WAIT,
      ST_H,
      ST_DONE
   } state_t;

   state_t            r_state, w_nxt_state;
   logic [NGBITS-1:0] r_step, w_nxt_step;
   logic [RIW-1:0]    r_j, w_nxt_j, w_j_inc;
   logic              r_use_r, w_nxt_use_r;
   logic              r_pre_start, w_nxt_pre_start;
   logic              r_rnd_start, w_nxt_rnd_start;
   logic              r_h_start, w_nxt_h_start;
   logic              r_ready_pulse, w_nxt_ready_pulse;
   logic [1:0]        r_ready_code, w_nxt_ready_code;
   logic [DW-1:0]     r_data, w_nxt_data;
   logic [F_NBITS-1:0] r_tau_q, w_nxt_tau_q;
   logic              r_proto_err, w_nxt_proto_err;
   logic              w_start_cycle;
   logic              w_any_done;

   // Next-state and next-output decode. A restart takes priority over
   // everything; done inputs landing in a start-pulse cycle are dropped.
   always_comb begin
      w_nxt_state       = r_state;
      w_nxt_step        = r_step;
      w_nxt_j           = r_j;
      w_nxt_use_r       = r_use_r;
      w_nxt_pre_start   = 1'b0;
      w_nxt_rnd_start   = 1'b0;
      w_nxt_h_start     = 1'b0;
      w_nxt_ready_pulse = 1'b0;
      w_nxt_ready_code  = r_ready_code;
      w_nxt_data        = r_data;
      w_nxt_tau_q       = r_tau_q;
      w_nxt_proto_err   = r_proto_err;
      w_j_inc           = r_j + 1'b1;
      w_start_cycle     = r_pre_start | r_rnd_start | r_h_start;
      w_any_done        = i_pre_done | i_rnd_done | i_h_done;

      if (i_en && i_restart) begin
         w_nxt_tau_q     = i_tau;
         w_nxt_step      = '0;
         w_nxt_pre_start = 1'b1;
         w_nxt_state     = ST_PRE;
      end else begin
         if (i_en) begin
            case (r_state)
               ST_PRE_WAIT: begin
                  w_nxt_tau_q     = i_tau;
                  w_nxt_pre_start = 1'b1;
                  w_nxt_state     = ST_PRE;
               end
               ST_RND_WAIT: begin
                  w_nxt_tau_q = i_tau;
                  w_nxt_j     = w_j_inc;
                  if (w_j_inc < NRND_V) begin
                     w_nxt_rnd_start = 1'b1;
                     w_nxt_use_r     = 1'b1;
                     w_nxt_state     = ST_RND;
                  end else begin
                     w_nxt_h_start = 1'b1;
                     w_nxt_state   = ST_H;
                  end
               end
               default: w_nxt_proto_err = 1'b1;
            endcase
         end

         if (!w_start_cycle) begin
            case (r_state)
               ST_PRE: begin
                  if (i_pre_done) begin
                     if (r_step < LAST_STEP) begin
                        w_nxt_step        = r_step + 1'b1;
                        w_nxt_ready_code  = CODE_PRE;
                        w_nxt_ready_pulse = 1'b1;
                        w_nxt_state       = ST_PRE_WAIT;
                     end else begin
                        w_nxt_j         = '0;
                        w_nxt_use_r     = 1'b0;
                        w_nxt_rnd_start = 1'b1;
                        w_nxt_state     = ST_RND;
                     end
                  end
                  if (i_rnd_done || i_h_done) w_nxt_proto_err = 1'b1;
               end
               ST_RND: begin
                  if (i_rnd_done) begin
                     w_nxt_data[DW-1 -: FJW] = i_rnd_fj;
                     w_nxt_ready_code        = CODE_FJ;
                     w_nxt_ready_pulse       = 1'b1;
                     w_nxt_state             = ST_RND_WAIT;
                  end
                  if (i_pre_done || i_h_done) w_nxt_proto_err = 1'b1;
               end
               ST_H: begin
                  if (i_h_done) begin
                     w_nxt_data        = i_h_pts;
                     w_nxt_ready_code  = CODE_H;
                     w_nxt_ready_pulse = 1'b1;
                     w_nxt_state       = ST_DONE;
                  end
                  if (i_pre_done || i_rnd_done) w_nxt_proto_err = 1'b1;
               end
               default: if (w_any_done) w_nxt_proto_err = 1'b1;
            endcase
         end
      end
   end

   // State and registered-output update with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state       <= ST_IDLE;
         r_step        <= '0;
         r_j           <= '0;
         r_use_r       <= 1'b0;
         r_pre_start   <= 1'b0;
         r_rnd_start   <= 1'b0;
         r_h_start     <= 1'b0;
         r_ready_pulse <= 1'b0;
         r_ready_code  <= '0;
         r_data        <= '0;
         r_tau_q       <= '0;
         r_proto_err   <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_step        <= w_nxt_step;
         r_j           <= w_nxt_j;
         r_use_r       <= w_nxt_use_r;
         r_pre_start   <= w_nxt_pre_start;
         r_rnd_start   <= w_nxt_rnd_start;
         r_h_start     <= w_nxt_h_start;
         r_ready_pulse <= w_nxt_ready_pulse;
         r_ready_code  <= w_nxt_ready_code;
         r_data        <= w_nxt_data;
         r_tau_q       <= w_nxt_tau_q;
         r_proto_err   <= w_nxt_proto_err;
      end
   end

   assign o_ready_pulse = r_ready_pulse;
   assign o_ready_code  = r_ready_code;
   assign o_data        = r_data;
   assign o_tau_q       = r_tau_q;
   assign o_pre_start   = r_pre_start;
   assign o_pre_step    = r_step;
   assign o_rnd_start   = r_rnd_start;
   assign o_rnd_idx     = r_j;
   assign o_rnd_use_r   = r_use_r;
   assign o_h_start     = r_h_start;
   assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign o_proto_err   = r_proto_err;

endmodule

// File: tb/tb_cmt_layer_sequencer.sv
// Testbench for cmt_layer_sequencer: engine and verifier models drive the
// sequencer; expected result strobes are queued when a done is driven and
// matched by a monitor whenever ready_pulse is observed.
module tb_cmt_layer_sequencer;

   localparam int NIN = 8;
   localparam int NG  = 8;
   localparam int F   = 16;
   localparam int NHP = 4;
   localparam int DW  = NHP * F;
   localparam int FJW = 3 * F;
   localparam int NR  = 6;
   localparam int NGB = 3;
   localparam int RIW = 4;

   logic           clk;
   logic           rstb;
   logic           i_en, i_restart;
   logic [F-1:0]   i_tau;
   logic           o_ready_pulse;
   logic [1:0]     o_ready_code;
   logic [DW-1:0]  o_data;
   logic [F-1:0]   o_tau_q;
   logic           o_pre_start;
   logic [NGB-1:0] o_pre_step;
   logic           i_pre_done;
   logic           o_rnd_start;
   logic [RIW-1:0] o_rnd_idx;
   logic           o_rnd_use_r;
   logic           i_rnd_done;
   logic [FJW-1:0] i_rnd_fj;
   logic           o_h_start;
   logic           i_h_done;
   logic [DW-1:0]  i_h_pts;
   logic           o_busy;
   logic           o_proto_err;

   typedef struct {
      logic [1:0]    code;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   exp_t          e_mon;
   logic [DW-1:0] m_data;
   logic [95:0]   allout;
   int            total = 0;
   int            bad   = 0;

   cmt_layer_sequencer #(.ninputs(NIN), .ngates(NG), .F_NBITS(F)) dut (
      .clk(clk), .rstb(rstb), .i_en(i_en), .i_restart(i_restart), .i_tau(i_tau),
      .o_ready_pulse(o_ready_pulse), .o_ready_code(o_ready_code), .o_data(o_data),
      .o_tau_q(o_tau_q), .o_pre_start(o_pre_start), .o_pre_step(o_pre_step),
      .i_pre_done(i_pre_done), .o_rnd_start(o_rnd_start), .o_rnd_idx(o_rnd_idx),
      .o_rnd_use_r(o_rnd_use_r), .i_rnd_done(i_rnd_done), .i_rnd_fj(i_rnd_fj),
      .o_h_start(o_h_start), .i_h_done(i_h_done), .i_h_pts(i_h_pts),
      .o_busy(o_busy), .o_proto_err(o_proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every observed strobe must match the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (o_ready_pulse === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse got code=%b data=%h want no pulse", o_ready_code, o_data);
         end else begin
            e_mon = sb.pop_front();
            if (o_ready_code !== e_mon.code || o_data !== e_mon.data) begin
               bad++;
               $display("FAIL pulse got code=%b data=%h want code=%b data=%h",
                        o_ready_code, o_data, e_mon.code, e_mon.data);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_en(input logic rs, input logic [F-1:0] t);
      i_en = 1'b1; i_restart = rs; i_tau = t;
      tick();
      i_en = 1'b0; i_restart = 1'b0;
   endtask

   function automatic logic start_sig(input int which);
      case (which)
         0:       return o_pre_start;
         1:       return o_rnd_start;
         default: return o_h_start;
      endcase
   endfunction

   task automatic wait_start(input int which, input string nm);
      int n;
      n = 0;
      while (start_sig(which) !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (start_sig(which) !== 1'b1) begin
         bad++;
         $display("FAIL %s_timeout got=0 want=1", nm);
      end
   endtask

   task automatic do_pre_phase();
      for (int s = 0; s < NGB; s++) begin
         wait_start(0, "pre_start");
         total++;
         if (o_pre_step !== NGB'(s)) begin
            bad++;
            $display("FAIL pre_step got=%0d want=%0d", o_pre_step, s);
         end
         tick(); tick();
         if (s < NGB - 1) sb.push_back('{code: 2'b00, data: m_data});
         i_pre_done = 1'b1;
         tick();
         i_pre_done = 1'b0;
         if (s < NGB - 1) begin
            tick();
            send_en(1'b0, F'($urandom));
         end
      end
   endtask

   task automatic do_rounds(input bit stop_in_h);
      logic [FJW-1:0] fj;
      logic [DW-1:0]  h;
      for (int j = 0; j < NR; j++) begin
         wait_start(1, "rnd_start");
         total++;
         if (o_rnd_idx !== RIW'(j) || o_rnd_use_r !== (j != 0)) begin
            bad++;
            $display("FAIL rnd_idx_use_r got=%0d/%b want=%0d/%b", o_rnd_idx, o_rnd_use_r, j, (j != 0));
         end
         tick(); tick();
         fj = FJW'({$urandom(), $urandom()});
         m_data[DW-1 -: FJW] = fj;
         sb.push_back('{code: 2'b01, data: m_data});
         i_rnd_fj = fj; i_rnd_done = 1'b1;
         tick();
         i_rnd_done = 1'b0;
         tick();
         send_en(1'b0, F'($urandom));
      end
      wait_start(2, "h_start");
      if (!stop_in_h) begin
         tick(); tick();
         h = DW'({$urandom(), $urandom()});
         m_data = h;
         sb.push_back('{code: 2'b10, data: h});
         i_h_pts = h; i_h_done = 1'b1;
         tick();
         i_h_done = 1'b0;
      end
   endtask

   task automatic test_reset();
      rstb = 1'b0; i_en = 0; i_restart = 0; i_tau = '0;
      i_pre_done = 0; i_rnd_done = 0; i_h_done = 0; i_rnd_fj = '0; i_h_pts = '0;
      m_data = '0;
      tick(); tick();
      allout = {o_ready_pulse, o_ready_code, o_data, o_tau_q, o_pre_start, o_pre_step,
                o_rnd_start, o_rnd_idx, o_rnd_use_r, o_h_start, o_busy, o_proto_err};
      total++;
      if (allout !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", allout);
      end
      rstb = 1'b1;
      total++;
      if (o_ready_pulse !== 1'b0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release got pulse=%b busy=%b want 0/0", o_ready_pulse, o_busy);
      end
   endtask

   task automatic test_full_run(input bit stop_in_h);
      send_en(1'b1, F'($urandom));
      do_pre_phase();
      do_rounds(stop_in_h);
      if (!stop_in_h) begin
         tick(); tick(); tick();
         total++;
         if (sb.size() != 0 || o_busy !== 1'b0 || o_ready_code !== 2'b10 || o_proto_err !== 1'b0) begin
            bad++;
            $display("FAIL run_end got pending=%0d busy=%b code=%b err=%b want 0/0/10/0",
                     sb.size(), o_busy, o_ready_code, o_proto_err);
         end
      end
   endtask

   task automatic test_latency_and_tau();
      send_en(1'b1, 16'h00aa);
      wait_start(0, "lat_pre_start");
      tick(); tick();
      sb.push_back('{code: 2'b00, data: m_data});
      i_pre_done = 1'b1;
      total++;
      if (o_ready_pulse !== 1'b0) begin
         bad++;
         $display("FAIL early_pulse got=1 want=0");
      end
      tick();
      i_pre_done = 1'b0;
      total++;
      if (o_ready_pulse !== 1'b1 || o_ready_code !== 2'b00) begin
         bad++;
         $display("FAIL pre_latency got pulse=%b code=%b want 1/00", o_ready_pulse, o_ready_code);
      end
      tick();
      send_en(1'b0, 16'h0001);
      wait_start(0, "lat_pre_start1");
      tick();
      sb.push_back('{code: 2'b00, data: m_data});
      i_pre_done = 1'b1;
      tick();
      i_pre_done = 1'b0;
      tick();
      send_en(1'b0, 16'h0002);
      wait_start(0, "lat_pre_start2");
      tick();
      i_pre_done = 1'b1;
      tick();
      i_pre_done = 1'b0;
      total++;
      if (o_rnd_start !== 1'b1 || o_rnd_idx !== '0 || o_rnd_use_r !== 1'b0) begin
         bad++;
         $display("FAIL rnd0_start got=%b/%0d/%b want 1/0/0", o_rnd_start, o_rnd_idx, o_rnd_use_r);
      end
      tick(); tick();
      i_rnd_fj = {16'd7, 16'd5, 16'd3};
      m_data[DW-1 -: FJW] = {16'd7, 16'd5, 16'd3};
      sb.push_back('{code: 2'b01, data: m_data});
      i_rnd_done = 1'b1;
      tick();
      i_rnd_done = 1'b0;
      total++;
      if (o_ready_pulse !== 1'b1 || o_ready_code !== 2'b01 ||
          o_data[DW-1 -: FJW] !== {16'd7, 16'd5, 16'd3} || o_data[F-1:0] !== m_data[F-1:0]) begin
         bad++;
         $display("FAIL fj_latency got pulse=%b code=%b data=%h want 1/01 data=%h",
                  o_ready_pulse, o_ready_code, o_data, m_data);
      end
      tick();
      send_en(1'b0, 16'h1234);
      total++;
      if (o_tau_q !== 16'h1234 || o_rnd_start !== 1'b1 || o_rnd_idx !== 4'd1) begin
         bad++;
         $display("FAIL tau_latch got tau=%h start=%b idx=%0d want 1234/1/1", o_tau_q, o_rnd_start, o_rnd_idx);
      end
      tick(); tick(); tick();
      total++;
      if (o_tau_q !== 16'h1234) begin
         bad++;
         $display("FAIL tau_hold got=%h want=1234", o_tau_q);
      end
   endtask

   task automatic test_restart_mid_round();
      i_rnd_fj = FJW'({$urandom(), $urandom()});
      i_rnd_done = 1'b1; i_en = 1'b1; i_restart = 1'b1; i_tau = 16'h5a5a;
      tick();
      i_rnd_done = 1'b0; i_en = 1'b0; i_restart = 1'b0;
      total++;
      if (o_ready_pulse !== 1'b0 || o_pre_start !== 1'b1 || o_pre_step !== '0 ||
          o_proto_err !== 1'b0 || o_tau_q !== 16'h5a5a) begin
         bad++;
         $display("FAIL restart got pulse=%b pre_start=%b step=%0d err=%b tau=%h want 0/1/0/0/5a5a",
                  o_ready_pulse, o_pre_start, o_pre_step, o_proto_err, o_tau_q);
      end
   endtask

   task automatic test_proto_err();
      do_pre_phase();
      wait_start(1, "perr_rnd_start");
      tick(); tick();
      i_rnd_fj = FJW'({$urandom(), $urandom()});
      m_data[DW-1 -: FJW] = i_rnd_fj;
      sb.push_back('{code: 2'b01, data: m_data});
      i_rnd_done = 1'b1;
      tick();
      i_rnd_done = 1'b0;
      tick();
      total++;
      if (o_proto_err !== 1'b0) begin
         bad++;
         $display("FAIL err_before got=%b want=0", o_proto_err);
      end
      i_h_done = 1'b1;
      tick();
      i_h_done = 1'b0;
      total++;
      if (o_ready_pulse !== 1'b0 || o_proto_err !== 1'b1 || o_busy !== 1'b1) begin
         bad++;
         $display("FAIL stray_h_done got pulse=%b err=%b busy=%b want 0/1/1", o_ready_pulse, o_proto_err, o_busy);
      end
      tick();
      send_en(1'b0, 16'h0003);
      total++;
      if (o_rnd_start !== 1'b1 || o_rnd_idx !== 4'd1) begin
         bad++;
         $display("FAIL state_kept got start=%b idx=%0d want 1/1", o_rnd_start, o_rnd_idx);
      end
      rstb = 1'b0;
      tick();
      rstb = 1'b1;
      tick();
      send_en(1'b0, 16'h0004);
      total++;
      if (o_proto_err !== 1'b1 || o_pre_start !== 1'b0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_en got err=%b pre_start=%b busy=%b want 1/0/0", o_proto_err, o_pre_start, o_busy);
      end
   endtask

   task automatic test_reset_mid_h();
      rstb = 1'b0;
      tick();
      rstb = 1'b1;
      tick();
      m_data = '0;
      test_full_run(1'b1);
      tick();
      total++;
      if (o_busy !== 1'b1) begin
         bad++;
         $display("FAIL in_h_busy got=%b want=1", o_busy);
      end
      rstb = 1'b0;
      #2;
      allout = {o_ready_pulse, o_ready_code, o_data, o_tau_q, o_pre_start, o_pre_step,
                o_rnd_start, o_rnd_idx, o_rnd_use_r, o_h_start, o_busy, o_proto_err};
      total++;
      if (allout !== '0) begin
         bad++;
         $display("FAIL async_reset got=%h want=0", allout);
      end
      tick();
      rstb = 1'b1;
      m_data = '0;
      total++;
      if (o_ready_pulse !== 1'b0) begin
         bad++;
         $display("FAIL post_release_pulse got=1 want=0");
      end
      tick();
      test_full_run(1'b0);
   endtask

   initial begin
      test_reset();
      test_full_run(1'b0);
      test_latency_and_tau();
      test_restart_mid_round();
      test_proto_err();
      test_reset_mid_h();
      tick(); tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL pending_expectations got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
